// File: rtl/dru_word_aligner.sv
// Word aligner for a data-recovery unit: packs 0..MAX_BITS recovered bits per cycle into comma-aligned words.
// Outputs are registered one clk after the carrying input cycle; no backpressure, every in_valid update is consumed.
module dru_word_aligner #(
  parameter int                WORD_W       = 10,
  parameter int                MAX_BITS     = 3,
  parameter logic [WORD_W-1:0] COMMA        = 10'b0011111010,
  parameter int                MISALIGN_MAX = 3
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic                             in_valid,
  input  logic [MAX_BITS-1:0]              in_bits,
  input  logic [$clog2(MAX_BITS+1)-1:0]    in_count,
  output logic [WORD_W-1:0]                word_out,
  output logic                             word_valid,
  output logic                             locked,
  output logic                             realign,
  output logic                             count_err
);

  localparam int HIST_W = WORD_W + MAX_BITS - 1;
  localparam int CIN_W  = $clog2(MAX_BITS + 1);
  localparam int BCNT_W = $clog2(WORD_W + 1);

  localparam logic [CIN_W-1:0]  CIN_MAX   = CIN_W'(MAX_BITS);
  localparam logic [BCNT_W-1:0] BCNT_WRAP = BCNT_W'(WORD_W);
  localparam logic [3:0]        MIS_LAST  = 4'(MISALIGN_MAX - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic [HIST_W-1:0]   r_hist;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [3:0]          r_mis;
  logic [WORD_W-1:0]   r_word;
  logic                r_word_vld;
  logic                r_realign;
  logic                r_count_err;

  logic                w_cnt_bad;
  logic                w_search;
  logic                w_comma;
  logic                w_done;
  state_t              w_state;
  logic [HIST_W-1:0]   w_hist;
  logic [BCNT_W-1:0]   w_bcnt;
  logic [3:0]          w_mis;
  logic [WORD_W-1:0]   w_word;
  logic                w_vld;
  logic                w_rlg;

  // Walk the cycle's bits oldest-first so comma/word events resolve in arrival order.
  always_comb begin
    w_cnt_bad = in_valid && (in_count > CIN_MAX);
    w_search  = (r_state == SEARCH);
    w_comma   = 1'b0;
    w_done    = 1'b0;
    w_state   = r_state;
    w_hist    = r_hist;
    w_bcnt    = r_bcnt;
    w_mis     = r_mis;
    w_word    = r_word;
    w_vld     = 1'b0;
    w_rlg     = 1'b0;
    if (in_valid && !w_cnt_bad) begin
      for (int i = 0; i < MAX_BITS; i++) begin
        if (i < int'(in_count)) begin
          w_hist  = {w_hist[HIST_W-2:0], in_bits[i]};
          w_comma = (w_hist[WORD_W-1:0] == COMMA);
          if (w_search) begin
            // Cycle began unaligned: every comma re-anchors, so the latest one wins.
            if (w_comma) begin
              w_state = LOCKED;
              w_bcnt  = '0;
              w_mis   = '0;
              w_word  = COMMA;
              w_vld   = 1'b1;
              w_rlg   = 1'b1;
            end else if (w_state == LOCKED) begin
              w_bcnt = w_bcnt + BCNT_W'(1);
            end
          end else begin
            w_bcnt = w_bcnt + BCNT_W'(1);
            w_done = (w_bcnt == BCNT_WRAP);
            if (w_done) begin
              w_bcnt = '0;
              if (!w_rlg) begin
                w_word = w_hist[WORD_W-1:0];
                w_vld  = 1'b1;
              end
            end
            if (w_comma) begin
              if (w_done) begin
                w_mis = '0;
              end else if (w_mis == MIS_LAST) begin
                w_mis  = '0;
                w_bcnt = '0;
                w_word = COMMA;
                w_vld  = 1'b1;
                w_rlg  = 1'b1;
              end else begin
                w_mis = w_mis + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state     <= SEARCH;
      r_hist      <= '0;
      r_bcnt      <= '0;
      r_mis       <= '0;
      r_word      <= '0;
      r_word_vld  <= 1'b0;
      r_realign   <= 1'b0;
      r_count_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_hist      <= w_hist;
      r_bcnt      <= w_bcnt;
      r_mis       <= w_mis;
      r_word      <= w_word;
      r_word_vld  <= w_vld;
      r_realign   <= w_rlg;
      r_count_err <= w_cnt_bad;
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_word_vld;
  assign locked     = (r_state == LOCKED);
  assign realign    = r_realign;
  assign count_err  = r_count_err;

endmodule

// File: tb/tb_dru_word_aligner.sv
// Directed bench for dru_word_aligner: default instance plus a MAX_BITS=2 instance for the over-count case.
module tb_dru_word_aligner;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       in_valid;
  logic [2:0] in_bits;
  logic [1:0] in_count;
  logic [9:0] word_out;
  logic       word_valid, locked, realign, count_err;

  logic       v2;
  logic [1:0] b2, c2;
  logic [9:0] w2_out;
  logic       w2_vld, w2_lck, w2_rlg, w2_cerr;

  int errors = 0;
  int checks = 0;

  logic [9:0] last_w;
  bit         q[$];
  int         e_pos[$];
  logic [9:0] e_word[$];
  bit         e_rlg[$];

  always #5 clk = ~clk;

  dru_word_aligner u_dut (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_bits(in_bits), .in_count(in_count),
    .word_out(word_out), .word_valid(word_valid), .locked(locked), .realign(realign), .count_err(count_err)
  );

  dru_word_aligner #(.MAX_BITS(2)) u_dut2 (
    .clk(clk), .aresetn(aresetn), .in_valid(v2), .in_bits(b2), .in_count(c2),
    .word_out(w2_out), .word_valid(w2_vld), .locked(w2_lck), .realign(w2_rlg), .count_err(w2_cerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) q.push_back(w[i]);
  endtask

  task automatic expect_word(input int pos, input logic [9:0] w, input bit r);
    e_pos.push_back(pos);
    e_word.push_back(w);
    e_rlg.push_back(r);
  endtask

  // mode 0: 3 bits/cycle; mode 1: random count/valid; mode 2: first cycle 2 bits then 3.
  task automatic feed(input int mode);
    int         pos = 0;
    int         cyc = 0;
    int         n;
    bit         v;
    bit         hit;
    logic [2:0] b;
    logic [9:0] ew;
    bit         er;
    while (q.size() > 0) begin
      cyc++;
      if (cyc > 300) begin
        checks++;
        errors++;
        $error("FAIL feed_timeout: observed %0d cycles expected <= 300", cyc);
        q.delete();
        break;
      end
      v = 1'b1;
      n = 3;
      if (mode == 1) begin
        if ($urandom_range(0, 4) == 0) v = 1'b0;
        n = int'($urandom_range(0, 3));
      end
      if (mode == 2 && cyc == 1) n = 2;
      if (!v) n = 0;
      if (n > q.size()) n = q.size();
      b = 3'($urandom);
      for (int i = 0; i < n; i++) b[i] = q.pop_front();
      @(negedge clk);
      in_valid = v;
      in_bits  = b;
      in_count = v ? 2'(n) : 2'($urandom);
      @(posedge clk);
      #1;
      hit = 1'b0;
      ew  = last_w;
      er  = 1'b0;
      while (e_pos.size() > 0 && e_pos[0] < pos + n) begin
        hit = 1'b1;
        ew  = e_word.pop_front();
        er  = e_rlg.pop_front();
        void'(e_pos.pop_front());
      end
      pos += n;
      chk("word_valid", {31'd0, word_valid}, {31'd0, hit});
      chk("word_out", {22'd0, word_out}, {22'd0, ew});
      chk("realign", {31'd0, realign}, {31'd0, er});
      chk("count_err", {31'd0, count_err}, 32'd0);
      last_w = ew;
    end
    in_valid = 1'b0;
  endtask

  task automatic drive2(input logic v, input logic [1:0] c, input logic [1:0] b);
    @(negedge clk);
    v2 = v;
    c2 = c;
    b2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    aresetn  = 1'b0;
    in_valid = 1'b0;
    in_bits  = '0;
    in_count = '0;
    v2       = 1'b0;
    b2       = '0;
    c2       = '0;
    last_w   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_word_out", {22'd0, word_out}, 32'd0);
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_realign", {31'd0, realign}, 32'd0);
    chk("rst_count_err", {31'd0, count_err}, 32'd0);
    chk("rst_locked2", {31'd0, w2_lck}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;

    // Unaligned stream with no run of five ones, so no comma can appear.
    for (int i = 0; i < 90; i++) q.push_back((i % 4 == 3) ? 1'b0 : bit'($urandom_range(0, 1)));
    feed(0);
    chk("search_locked", {31'd0, locked}, 32'd0);

    // Comma's last bit lands at in_bits[1] of its cycle.
    q.push_back(1'b0);
    push_word(10'h0FA);
    push_word(10'h155);
    push_word(10'h2AA);
    expect_word(10, 10'h0FA, 1'b1);
    expect_word(20, 10'h155, 1'b0);
    expect_word(30, 10'h2AA, 1'b0);
    feed(0);
    chk("lock_locked", {31'd0, locked}, 32'd1);

    push_word(10'h0FA);
    push_word(10'h155);
    push_word(10'h2AA);
    expect_word(9, 10'h0FA, 1'b0);
    expect_word(19, 10'h155, 1'b0);
    expect_word(29, 10'h2AA, 1'b0);
    feed(1);
    chk("varcnt_locked", {31'd0, locked}, 32'd1);

    // Three commas shifted one bit late; the third realigns and drops the word ending alongside it.
    q.push_back(1'b0);
    push_word(10'h0FA);
    push_word(10'h0FA);
    push_word(10'h0FA);
    push_word(10'h155);
    push_word(10'h2AA);
    expect_word(9, 10'h07D, 1'b0);
    expect_word(19, 10'h07D, 1'b0);
    expect_word(30, 10'h0FA, 1'b1);
    expect_word(40, 10'h155, 1'b0);
    expect_word(50, 10'h2AA, 1'b0);
    feed(2);
    chk("shift_locked", {31'd0, locked}, 32'd1);

    // Over-count update on the MAX_BITS=2 instance must be dropped mid-comma.
    drive2(1'b1, 2'd2, 2'b00);
    chk("cerr_idle", {31'd0, w2_cerr}, 32'd0);
    drive2(1'b1, 2'd2, 2'b11);
    drive2(1'b1, 2'd3, 2'b10);
    chk("cerr_pulse", {31'd0, w2_cerr}, 32'd1);
    chk("cerr_no_word", {31'd0, w2_vld}, 32'd0);
    drive2(1'b1, 2'd2, 2'b11);
    chk("cerr_clear", {31'd0, w2_cerr}, 32'd0);
    drive2(1'b1, 2'd2, 2'b01);
    drive2(1'b1, 2'd2, 2'b01);
    chk("cerr_word_valid", {31'd0, w2_vld}, 32'd1);
    chk("cerr_word_out", {22'd0, w2_out}, 32'h0FA);
    chk("cerr_realign", {31'd0, w2_rlg}, 32'd1);
    chk("cerr_locked", {31'd0, w2_lck}, 32'd1);
    drive2(1'b0, 2'd0, 2'b00);
    chk("cerr_valid_drop", {31'd0, w2_vld}, 32'd0);

    // Reset halfway through a word while locked.
    q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0);
    feed(0);
    @(negedge clk);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_word_out", {22'd0, word_out}, 32'd0);
    chk("mid_rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    chk("mid_rst_realign", {31'd0, realign}, 32'd0);
    chk("mid_rst_count_err", {31'd0, count_err}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    last_w  = '0;
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
    push_word(10'h2AA);
    feed(0);
    chk("post_rst_locked", {31'd0, locked}, 32'd0);
    push_word(10'h0FA);
    push_word(10'h155);
    expect_word(9, 10'h0FA, 1'b1);
    expect_word(19, 10'h155, 1'b0);
    feed(0);
    chk("relock_locked", {31'd0, locked}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
